// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and sizing constants for the UART receiver.
package uart_rx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } state_e;
  localparam int PRESCALE_MIN = 8;
  localparam int PRESCALE_MAX = 32;
  localparam int DATA_BITS = 8;
  localparam int EDGE_W = 6;
  localparam int BIT_W = 4;
endpackage

// File: rtl/edge_bit_cnt.sv
// edge_bit_cnt: oversampling edge counter and frame bit counter, cleared whenever enable is low.
module edge_bit_cnt
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt
);
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic wrap;
  always_comb begin
    wrap = edge_q == EDGE_W'(prescale - 1'b1);
    edge_d = (!enable || wrap) ? '0 : edge_q + 1'b1;
    bit_d = !enable ? '0 : wrap ? bit_q + 1'b1 : bit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= '0;
      bit_q <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q <= bit_d;
    end
  end
  assign edge_cnt = edge_q;
  assign bit_cnt = bit_q;
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller; sequences start/data/parity/stop bits and strobes the checkers.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic [EDGE_W-1:0] prescale,
  input  logic              par_en,
  input  logic [EDGE_W-1:0] edge_cnt,
  input  logic [BIT_W-1:0]  bit_cnt,
  input  logic              strt_glitch,
  input  logic              par_err,
  input  logic              stp_err,
  output logic              enable,
  output logic              dat_samp_en,
  output logic              strt_chk_en,
  output logic              par_chk_en,
  output logic              stp_chk_en,
  output logic              deser_en,
  output logic              data_valid
);
  state_e state_q, state_d;
  logic [EDGE_W-1:0] ps_q, ps_d;
  logic stp_q, stp_d;
  logic bit_end, chk_pt;
  assign bit_end = edge_cnt == EDGE_W'(ps_q - 1'b1);
  assign chk_pt = edge_cnt == EDGE_W'((ps_q >> 1) + 6'd2);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ps_q <= EDGE_W'(PRESCALE_MIN);
      stp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q <= ps_d;
      stp_q <= stp_d;
    end
  end
  // stop result is registered so data_valid never follows stp_err combinationally
  always_comb begin
    state_d = state_q;
    ps_d = (state_q == IDLE && !rx_in) ? prescale : ps_q;
    stp_d = (state_q == STOP && bit_end) ? stp_err : stp_q;
    unique case (state_q)
      IDLE:    state_d = rx_in ? IDLE : START;
      START:   if (bit_end) state_d = strt_glitch ? IDLE : DATA;
      DATA:    if (bit_end && bit_cnt == BIT_W'(DATA_BITS)) state_d = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = par_err ? IDLE : STOP;
      STOP:    if (bit_end) state_d = CHECK;
      CHECK:   state_d = rx_in ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    enable = state_q inside {START, DATA, PARITY, STOP};
    dat_samp_en = enable;
    strt_chk_en = state_q == START && chk_pt;
    par_chk_en = state_q == PARITY && chk_pt;
    stp_chk_en = state_q == STOP && chk_pt;
    deser_en = state_q == DATA && chk_pt;
    data_valid = state_q == CHECK && !stp_q;
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: drives serial frames into uart_rx_fsm + edge_bit_cnt and checks pulse counts and timing.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;
  logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, par_en = 1'b0;
  logic [EDGE_W-1:0] prescale = 6'd8, fps = 6'd8, edge_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
  logic enable, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;
  int checks = 0, errs = 0, cyc = 0;
  int dv_n, dv_cyc, dv_first, deser_n, en_n, strt_n, par_n, stp_n, bad_n, last_edge;
  always #5 clk = ~clk;
  uart_rx_fsm dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch), .par_err(par_err),
    .stp_err(stp_err), .enable(enable), .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .deser_en(deser_en), .data_valid(data_valid)
  );
  edge_bit_cnt ebc (
    .clk(clk), .rst(rst), .enable(enable), .prescale(fps), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_valid) begin
      dv_n++;
      if (dv_n == 1) dv_first = cyc;
      dv_cyc = cyc;
    end
    deser_n += int'(deser_en);
    en_n += int'(enable);
    strt_n += int'(strt_chk_en);
    par_n += int'(par_chk_en);
    stp_n += int'(stp_chk_en);
    if ((deser_en | strt_chk_en | par_chk_en | stp_chk_en) && int'(edge_cnt) != int'(fps) / 2 + 2) bad_n++;
    if (dat_samp_en !== enable) bad_n++;
    if (enable) last_edge = int'(edge_cnt);
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic clear();
    dv_n = 0; dv_cyc = -1; dv_first = -1; deser_n = 0; en_n = 0;
    strt_n = 0; par_n = 0; stp_n = 0; bad_n = 0; last_edge = -1;
  endtask
  // entered at a falling clock edge; returns at the falling edge of the cycle after the stop bit end
  task automatic send(input int ps, input int pe, input logic [7:0] d, input int g, input int perr,
                      input int se, input int chg, output int t0);
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    rx_in = 1'b0; t0 = cyc;
    repeat (ps) @(negedge clk);
    strt_glitch = g[0];
    if (chg != 0) prescale = (ps == 8) ? 6'd32 : 6'd8;
    if (g != 0) begin
      rx_in = 1'b1;
      repeat (2 * ps) @(negedge clk);
    end else begin
      for (int i = 0; i < 8; i++) begin
        rx_in = d[i];
        repeat (ps) @(negedge clk);
      end
      if (pe != 0) begin
        rx_in = ^d;
        repeat (ps) @(negedge clk);
        par_err = perr[0];
      end
      rx_in = 1'b1;
      repeat (ps / 2 + 4) @(negedge clk);
      stp_err = se[0];
      repeat (ps / 2 - 3) @(negedge clk);
    end
  endtask
  task automatic wait_done();
    int done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (en_n > 0 && !enable) begin done = 1; break; end
    end
    chk("frame_done", done, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic run_frame(input int ps, input int pe, input logic [7:0] d, input int g,
                           input int perr, input int se, input int chg);
    int t0, pabort, len;
    @(negedge clk); #1;
    clear();
    fps = 6'(ps); prescale = 6'(ps); par_en = pe[0];
    @(negedge clk);
    send(ps, pe, d, g, perr, se, chg, t0);
    wait_done();
    pabort = (pe != 0 && perr != 0) ? 1 : 0;
    len = (10 + pe) * ps;
    chk("enable_cycles", en_n, g != 0 ? ps : pabort != 0 ? 10 * ps : len);
    chk("deser_pulses", deser_n, g != 0 ? 0 : 8);
    chk("data_valid_pulses", dv_n, (g == 0 && pabort == 0 && se == 0) ? 1 : 0);
    chk("strt_chk_pulses", strt_n, 1);
    chk("par_chk_pulses", par_n, (g == 0 && pe != 0) ? 1 : 0);
    chk("stp_chk_pulses", stp_n, (g == 0 && pabort == 0) ? 1 : 0);
    chk("strobe_position", bad_n, 0);
    chk("last_bit_end_edge", last_edge, ps - 1);
    if (g == 0 && pabort == 0 && se == 0) chk("data_valid_offset", dv_cyc - t0, len + 1);
  endtask
  initial begin
    int t1, t2, e0, hit;
    int pss[3] = '{8, 16, 32};
    clear();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", int'({enable, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid}), 0);
    rst = 1'b0;
    run_frame(8, 0, 8'hA5, 0, 0, 0, 0);
    run_frame(16, 1, 8'h3C, 0, 1, 0, 0);
    run_frame(8, 0, 8'h5A, 1, 0, 0, 0);
    run_frame(32, 0, 8'hC3, 0, 0, 1, 0);
    run_frame(16, 1, 8'h81, 0, 0, 0, 1);
    // back-to-back: second start bit lands in the CHECK cycle
    @(negedge clk); #1;
    clear();
    fps = 6'd8; prescale = 6'd8; par_en = 1'b0;
    @(negedge clk);
    send(8, 0, 8'h12, 0, 0, 0, 0, t1);
    send(8, 0, 8'hED, 0, 0, 0, 0, t2);
    wait_done();
    chk("b2b_dv_pulses", dv_n, 2);
    chk("b2b_deser_pulses", deser_n, 16);
    chk("b2b_first_dv", dv_first - t1, 81);
    chk("b2b_second_start", t2 - t1, 81);
    chk("b2b_second_dv", dv_cyc - t2, 81);
    chk("b2b_enable_cycles", en_n, 160);
    chk("b2b_strobe_position", bad_n, 0);
    // reset mid-DATA with a prescale change already applied
    @(negedge clk); #1;
    clear();
    fps = 6'd16; prescale = 6'd16; par_en = 1'b0;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    rx_in = 1'b1; prescale = 6'd8;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (bit_cnt == 4'd4) begin hit = 1; break; end
    end
    chk("rst_reach_bit4", hit, 1);
    chk("rst_deser_before", deser_n, 3);
    chk("rst_strobe_position", bad_n, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_outputs", int'({enable, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid}), 0);
    rst = 1'b0;
    e0 = en_n;
    repeat (40) @(negedge clk);
    #1;
    chk("rst_stays_idle", en_n - e0, 0);
    chk("rst_no_dv", dv_n, 0);
    for (int n = 0; n < 8; n++) begin
      run_frame(pss[$urandom_range(0, 2)], int'($urandom_range(0, 1)), 8'($urandom),
                int'($urandom_range(0, 4) == 0), int'($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
